// File: rtl/nth_prime_sequencer.sv
// Walks candidates 2,3,5,7,... through an external is_prime core and reports the Nth prime.
// Flags overflow when candidates exceed MAX_VALUE and timeout when the core stalls.
module nth_prime_sequencer #(
    parameter int unsigned     W         = 32,
    parameter logic [W-1:0]    MAX_VALUE = 32'hFFFFFFFB,
    parameter int unsigned     TIMEOUT   = 1 << 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] target_n,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] prime_out,
    output logic [W-1:0] prime_count,
    output logic         err_overflow,
    output logic         err_timeout,
    output logic         ip_start,
    output logic [W-1:0] ip_value,
    input  logic         ip_done,
    input  logic         ip_result
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_SETTLE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t       state;
    logic [W-1:0] target;
    logic [W-1:0] cand;
    logic [31:0]  tcnt;
    logic         result;

    logic [W-1:0] count_inc;
    logic [W:0]   plus_two;
    logic [W-1:0] next_cand;
    logic         wrap;
    logic [31:0]  tcnt_inc;

    always_comb begin
        count_inc = prime_count + W'(result);
        plus_two  = {1'b0, cand} + (W+1)'(2);
        wrap      = plus_two[W];
        next_cand = (cand == W'(2)) ? W'(3) : plus_two[W-1:0];
        tcnt_inc  = tcnt + 32'd1;
    end

    // ip_start is raised on entry to ISSUE so the pulse coincides with the ISSUE cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            prime_out    <= '0;
            prime_count  <= '0;
            err_overflow <= 1'b0;
            err_timeout  <= 1'b0;
            ip_start     <= 1'b0;
            ip_value     <= '0;
            target       <= '0;
            cand         <= '0;
            tcnt         <= '0;
            result       <= 1'b0;
        end else begin
            ip_start <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        target       <= target_n;
                        cand         <= W'(2);
                        prime_count  <= '0;
                        prime_out    <= '0;
                        err_overflow <= 1'b0;
                        err_timeout  <= 1'b0;
                        if (target_n == '0) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_DONE;
                        end else begin
                            done     <= 1'b0;
                            busy     <= 1'b1;
                            ip_start <= 1'b1;
                            ip_value <= W'(2);
                            state    <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    tcnt  <= '0;
                    state <= S_SETTLE;
                end
                S_SETTLE: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (ip_done) begin
                        result <= ip_result;
                        state  <= S_CHECK;
                    end else if (TIMEOUT != 0 && tcnt_inc == 32'(TIMEOUT)) begin
                        err_timeout <= 1'b1;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_DONE;
                    end else begin
                        tcnt <= tcnt_inc;
                    end
                end
                S_CHECK: begin
                    prime_count <= count_inc;
                    if (result && count_inc == target) begin
                        prime_out <= cand;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_DONE;
                    end else if (wrap || next_cand > MAX_VALUE) begin
                        err_overflow <= 1'b1;
                        prime_out    <= '0;
                        done         <= 1'b1;
                        busy         <= 1'b0;
                        state        <= S_DONE;
                    end else begin
                        cand     <= next_cand;
                        ip_value <= next_cand;
                        ip_start <= 1'b1;
                        state    <= S_ISSUE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nth_prime_sequencer.sv
// Randomized bench: two sequencers (default range / MAX_VALUE=20) driven by behavioural
// is_prime cores with random latency; results compared against a trial-division model.
module tb_nth_prime_sequencer;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   start;
    logic [W-1:0] target_n;
    logic [1:0]   busy, done, err_ovf, err_to, ips, ipd, ipr;
    logic [W-1:0] po  [2];
    logic [W-1:0] pc  [2];
    logic [W-1:0] ipv [2];

    int unsigned  checks = 0;
    int unsigned  errors = 0;
    int unsigned  hold_viol = 0;
    int unsigned  lat_cnt [2];
    logic [W-1:0] held [2];
    bit           stall = 1'b0;
    logic [W-1:0] seen0[$];
    logic [W-1:0] seen1[$];
    logic [W-1:0] expq[$];

    always #5 clk = ~clk;

    nth_prime_sequencer #(.TIMEOUT(64)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .target_n(target_n),
        .busy(busy[0]), .done(done[0]), .prime_out(po[0]), .prime_count(pc[0]),
        .err_overflow(err_ovf[0]), .err_timeout(err_to[0]),
        .ip_start(ips[0]), .ip_value(ipv[0]), .ip_done(ipd[0]), .ip_result(ipr[0])
    );

    nth_prime_sequencer #(.MAX_VALUE(32'd20)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .target_n(target_n),
        .busy(busy[1]), .done(done[1]), .prime_out(po[1]), .prime_count(pc[1]),
        .err_overflow(err_ovf[1]), .err_timeout(err_to[1]),
        .ip_start(ips[1]), .ip_value(ipv[1]), .ip_done(ipd[1]), .ip_result(ipr[1])
    );

    function automatic bit is_prime(input int unsigned v);
        if (v < 2) return 1'b0;
        for (int unsigned d = 2; d * d <= v; d++)
            if (v % d == 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Behavioural core: drops done after start, answers after 1..4 cycles (core 0 can stall).
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                lat_cnt[i] <= 0;
                ipd[i]     <= 1'b0;
                ipr[i]     <= 1'b0;
            end else if (ips[i]) begin
                lat_cnt[i] <= $urandom_range(1, 4);
                ipd[i]     <= 1'b0;
                held[i]    <= ipv[i];
            end else if (lat_cnt[i] != 0 && !(stall && i == 0)) begin
                if (ipv[i] !== held[i]) hold_viol <= hold_viol + 1;
                lat_cnt[i] <= lat_cnt[i] - 1;
                if (lat_cnt[i] == 1) begin
                    ipd[i] <= 1'b1;
                    ipr[i] <= is_prime(held[i]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (ips[0] === 1'b1) seen0.push_back(ipv[0]);
        if (ips[1] === 1'b1) seen1.push_back(ipv[1]);
    end

    task automatic model(input int unsigned n, input int unsigned maxv,
                         output int unsigned epo, output int unsigned ecnt, output bit eovf);
        int unsigned c;
        expq.delete();
        epo = 0; ecnt = 0; eovf = 1'b0;
        if (n != 0) begin
            c = 2;
            while (1) begin
                expq.push_back(c);
                if (is_prime(c)) ecnt++;
                if (ecnt == n) begin epo = c; break; end
                c = (c == 2) ? 3 : c + 2;
                if (c > maxv) begin eovf = 1'b1; break; end
            end
        end
    endtask

    task automatic run_search(input int sel, input int unsigned n, input bit poke);
        int unsigned  epo, ecnt, cyc;
        bit           eovf;
        logic [W-1:0] q[$];
        model(n, (sel == 1) ? 20 : 32'hFFFFFFFB, epo, ecnt, eovf);
        @(posedge clk); #1;
        seen0.delete(); seen1.delete();
        target_n   = n;
        start[sel] = 1'b1;
        @(posedge clk); #1;
        start = '0;
        if (n == 0) begin
            chk("n0_done_next", 32'(done[sel]), 1);
        end else begin
            chk("busy_after_start", 32'(busy[sel]), 1);
            chk("done_cleared", 32'(done[sel]), 0);
        end
        cyc = 1;
        while (!done[sel] && cyc < 100000) begin
            start[sel] = poke && cyc == 6;
            if (poke && cyc == 6) target_n = $urandom;
            @(posedge clk); #1;
            start = '0;
            cyc++;
        end
        q = (sel == 1) ? seen1 : seen0;
        chk("done", 32'(done[sel]), 1);
        chk("busy_low", 32'(busy[sel]), 0);
        chk("prime_out", po[sel], epo);
        chk("prime_count", pc[sel], ecnt);
        chk("err_overflow", 32'(err_ovf[sel]), 32'(eovf));
        chk("err_timeout", 32'(err_to[sel]), 0);
        chk("pulses", 32'(q.size()), 32'(expq.size()));
        if (expq.size() <= 64) begin
            for (int i = 0; i < q.size() && i < expq.size(); i++)
                chk("ip_value", q[i], expq[i]);
        end else if (q.size() != 0) begin
            chk("last_ip_value", q[q.size()-1], expq[expq.size()-1]);
        end
    endtask

    initial begin
        int unsigned cyc;
        int unsigned n;
        rst_n = 1'b0; start = '0; target_n = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_busy", 32'(busy[i]), 0);
            chk("rst_done", 32'(done[i]), 0);
            chk("rst_prime_out", po[i], 0);
            chk("rst_ip_value", ipv[i], 0);
        end
        rst_n = 1'b1;

        run_search(0, 1, 1'b0);
        run_search(0, 6, 1'b0);
        run_search(0, 0, 1'b0);
        run_search(0, 1000, 1'b1);
        for (int k = 0; k < 8; k++) begin
            n = $urandom_range(0, 60);
            run_search(0, n, n >= 3);
        end
        run_search(1, 10, 1'b0);
        run_search(1, 8, 1'b0);
        run_search(1, 9, 1'b1);
        run_search(1, 0, 1'b0);
        for (int k = 0; k < 4; k++) run_search(1, $urandom_range(1, 12), 1'b0);

        // Stalled core: timeout must fire after ISSUE + SETTLE + 64 WAIT cycles.
        stall = 1'b1;
        seen0.delete();
        @(posedge clk); #1;
        target_n = 5; start[0] = 1'b1;
        @(posedge clk); #1;
        start = '0;
        cyc = 0;
        while (!done[0] && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("timeout_cycles", cyc, 66);
        chk("timeout_flag", 32'(err_to[0]), 1);
        chk("timeout_no_ovf", 32'(err_ovf[0]), 0);
        chk("timeout_count", pc[0], 0);
        chk("timeout_pulses", 32'(seen0.size()), 1);
        stall = 1'b0;

        @(posedge clk); #1;
        target_n = 100; start[0] = 1'b1;
        @(posedge clk); #1;
        start = '0;
        repeat (40) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_busy", 32'(busy[0]), 0);
        chk("mid_rst_done", 32'(done[0]), 0);
        chk("mid_rst_ip_start", 32'(ips[0]), 0);
        chk("mid_rst_errs", 32'({err_ovf[0], err_to[0]}), 0);
        chk("mid_rst_prime_out", po[0], 0);
        chk("mid_rst_count", pc[0], 0);
        chk("mid_rst_ip_value", ipv[0], 0);
        rst_n = 1'b1;
        run_search(0, 3, 1'b0);

        chk("ip_value_hold", hold_viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
